// File: rtl/qoa_spi_host.sv
// qoa_spi_host: SPI mode-0 master (CPOL=0, CPHA=0, MSB first, active-low CS)
// for the QOA decoder's SPI slave port. It converts a byte-level valid/ready
// stream into SCLK/MOSI/CS_N and assembles MISO into bytes and 16-bit words.
//
// Parameters:
//   CLK_DIV        SCLK half-period in clk cycles (>=1)
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   tx_valid       byte offered for transmission
//   tx_data        byte to shift out, MSB first
//   tx_last        qualifies tx_data; CS_N deasserts after this byte
//   tx_ready       byte accepted when tx_valid && tx_ready
//   rx_valid       one-cycle pulse, rx_data valid
//   rx_data        byte received during the last completed byte
//   rx_word_valid  one-cycle pulse on every 2nd byte of a frame
//   rx_word        {1st byte, 2nd byte} of the current byte pair
//   busy           high whenever not idle
//   spi_sclk       serial clock, idle low
//   spi_mosi       serial data out
//   spi_miso       serial data in (synchronous to clk)
//   spi_cs_n       chip select, active low
module qoa_spi_host #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  input  logic        tx_last,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_word_valid,
  output logic [15:0] rx_word,
  output logic        busy,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
);

  // Counter spans 0..2*CLK_DIV-1 so GAP can reuse it for both halves.
  localparam int unsigned CNT_W = $clog2(2 * CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CS_UP     = CNT_W'(CLK_DIV);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOW  = 3'd1,
    ST_HIGH = 3'd2,
    ST_WAIT = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [6:0]       tx_sh_q, tx_sh_d;   // remaining bits after the one on MOSI
  logic [6:0]       rx_sh_q, rx_sh_d;   // bits sampled so far in this byte
  logic             last_q, last_d;
  logic             pair_q, pair_d;     // set when a first-of-pair byte is held
  logic [7:0]       first_q, first_d;

  logic             tx_ready_d, rx_valid_d, rx_word_valid_d, busy_d;
  logic             sclk_d, mosi_d, cs_n_d;
  logic [7:0]       rx_data_d;
  logic [15:0]      rx_word_d;

  logic             accept;
  logic             half_done;
  logic             bit_end;
  logic [7:0]       byte_in;

  assign accept    = tx_valid && tx_ready;
  assign half_done = (cnt_q == HALF_LAST);
  // Last clk cycle of HIGH: MISO is sampled and SCLK falls on this edge.
  assign bit_end   = (state_q == ST_HIGH) && half_done;
  assign byte_in   = {rx_sh_q, spi_miso};

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      tx_sh_q       <= '0;
      rx_sh_q       <= '0;
      last_q        <= 1'b0;
      pair_q        <= 1'b0;
      first_q       <= '0;
      tx_ready      <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_word_valid <= 1'b0;
      rx_word       <= '0;
      busy          <= 1'b0;
      spi_sclk      <= 1'b0;
      spi_mosi      <= 1'b0;
      spi_cs_n      <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      tx_sh_q       <= tx_sh_d;
      rx_sh_q       <= rx_sh_d;
      last_q        <= last_d;
      pair_q        <= pair_d;
      first_q       <= first_d;
      tx_ready      <= tx_ready_d;
      rx_valid      <= rx_valid_d;
      rx_data       <= rx_data_d;
      rx_word_valid <= rx_word_valid_d;
      rx_word       <= rx_word_d;
      busy          <= busy_d;
      spi_sclk      <= sclk_d;
      spi_mosi      <= mosi_d;
      spi_cs_n      <= cs_n_d;
    end
  end

  // Next-state and half-period counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (accept) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      end
      ST_LOW: begin
        if (half_done) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (half_done) begin
          cnt_d = '0;
          if (bit_q != 3'd0) state_d = ST_LOW;
          else if (last_q)   state_d = ST_GAP;
          else               state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Datapath and next output values
  always_comb begin
    bit_d           = bit_q;
    tx_sh_d         = tx_sh_q;
    rx_sh_d         = rx_sh_q;
    last_d          = last_q;
    pair_d          = pair_q;
    first_d         = first_q;
    rx_valid_d      = 1'b0;
    rx_word_valid_d = 1'b0;
    rx_data_d       = rx_data;
    rx_word_d       = rx_word;
    mosi_d          = spi_mosi;

    if (accept) begin
      tx_sh_d = tx_data[6:0];
      last_d  = tx_last;
      bit_d   = 3'd7;
      mosi_d  = tx_data[7];
      if (state_q == ST_IDLE) pair_d = 1'b0;
    end

    if (bit_end) begin
      rx_sh_d = byte_in[6:0];
      if (bit_q != 3'd0) begin
        bit_d   = 3'(bit_q - 3'd1);
        mosi_d  = tx_sh_q[6];
        tx_sh_d = {tx_sh_q[5:0], 1'b0};
      end else begin
        rx_valid_d = 1'b1;
        rx_data_d  = byte_in;
        if (pair_q) begin
          rx_word_valid_d = 1'b1;
          rx_word_d       = {first_q, byte_in};
        end else begin
          first_d = byte_in;
        end
        pair_d = !pair_q;
      end
    end

    // Pin-level outputs are decoded from the next state so they stay registered.
    sclk_d     = (state_d == ST_HIGH);
    tx_ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT);
    busy_d     = (state_d != ST_IDLE);
    cs_n_d     = !((state_d == ST_LOW) || (state_d == ST_HIGH) ||
                   (state_d == ST_WAIT) ||
                   ((state_d == ST_GAP) && (cnt_d < CS_UP)));
  end

endmodule

// File: tb/tb_qoa_spi_host.sv
// Directed bench for qoa_spi_host: one instance at CLK_DIV=2, one at CLK_DIV=1,
// each with a behavioural mode-0 slave that returns per-frame response bytes.
module tb_qoa_spi_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // CLK_DIV=2 instance
  logic        rst2_n, tv2, tl2, tr2, rv2, rwv2, busy2, sclk2, mosi2, cs2;
  logic        miso2 = 1'b0;
  logic [7:0]  td2, rd2;
  logic [15:0] rw2;

  // CLK_DIV=1 instance
  logic        rst1_n, tv1, tl1, tr1, rv1, rwv1, busy1, sclk1, mosi1, cs1;
  logic        miso1 = 1'b0;
  logic [7:0]  td1, rd1;
  logic [15:0] rw1;

  qoa_spi_host #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .tx_valid(tv2), .tx_data(td2), .tx_last(tl2),
    .tx_ready(tr2), .rx_valid(rv2), .rx_data(rd2), .rx_word_valid(rwv2),
    .rx_word(rw2), .busy(busy2), .spi_sclk(sclk2), .spi_mosi(mosi2),
    .spi_miso(miso2), .spi_cs_n(cs2)
  );

  qoa_spi_host #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .tx_valid(tv1), .tx_data(td1), .tx_last(tl1),
    .tx_ready(tr1), .rx_valid(rv1), .rx_data(rd1), .rx_word_valid(rwv1),
    .rx_word(rw1), .busy(busy1), .spi_sclk(sclk1), .spi_mosi(mosi1),
    .spi_miso(miso1), .spi_cs_n(cs1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse counters
  int rv2_n = 0, rwv2_n = 0, rv1_n = 0, rwv1_n = 0;
  always @(posedge clk) begin
    if (rv2 === 1'b1)  rv2_n  <= rv2_n + 1;
    if (rwv2 === 1'b1) rwv2_n <= rwv2_n + 1;
    if (rv1 === 1'b1)  rv1_n  <= rv1_n + 1;
    if (rwv1 === 1'b1) rwv1_n <= rwv1_n + 1;
  end

  // Mode-0 slave models: MISO presented at CS fall, advanced on SCLK fall,
  // MOSI captured on SCLK rise. Per-frame counters restart at each CS fall.
  logic [7:0] resp2 [4];
  logic [7:0] s2_mb [4];
  logic [7:0] s2_sh, s2_cap;
  logic [1:0] s2_bidx;
  int         s2_nb, s2_rises, s2_falls = 0;
  logic       s2_csp = 1'b1, s2_sckp = 1'b0;

  always @(cs2 or sclk2) begin
    if (s2_csp && !cs2) begin
      s2_falls++; s2_bidx = '0; s2_nb = 0; s2_rises = 0;
      s2_sh = resp2[0]; miso2 = s2_sh[7];
    end else if (!cs2 && sclk2 && !s2_sckp) begin
      s2_rises++; s2_cap = {s2_cap[6:0], mosi2};
    end else if (!cs2 && !sclk2 && s2_sckp) begin
      s2_nb++;
      if (s2_nb == 8) begin
        s2_mb[s2_bidx] = s2_cap; s2_bidx++; s2_nb = 0; s2_sh = resp2[s2_bidx];
      end else begin
        s2_sh = {s2_sh[6:0], 1'b0};
      end
      miso2 = s2_sh[7];
    end
    s2_csp = cs2; s2_sckp = sclk2;
  end

  logic [7:0] resp1 [4];
  logic [7:0] s1_mb [4];
  logic [7:0] s1_sh, s1_cap;
  logic [1:0] s1_bidx;
  int         s1_nb, s1_rises;
  logic       s1_csp = 1'b1, s1_sckp = 1'b0;

  always @(cs1 or sclk1) begin
    if (s1_csp && !cs1) begin
      s1_bidx = '0; s1_nb = 0; s1_rises = 0;
      s1_sh = resp1[0]; miso1 = s1_sh[7];
    end else if (!cs1 && sclk1 && !s1_sckp) begin
      s1_rises++; s1_cap = {s1_cap[6:0], mosi1};
    end else if (!cs1 && !sclk1 && s1_sckp) begin
      s1_nb++;
      if (s1_nb == 8) begin
        s1_mb[s1_bidx] = s1_cap; s1_bidx++; s1_nb = 0; s1_sh = resp1[s1_bidx];
      end else begin
        s1_sh = {s1_sh[6:0], 1'b0};
      end
      miso1 = s1_sh[7];
    end
    s1_csp = cs1; s1_sckp = sclk1;
  end

  task send2(input logic [7:0] d, input logic l);
    int w;
    w = 0;
    while (tr2 !== 1'b1 && w < 500) begin w++; tick; end
    tv2 = 1'b1; td2 = d; tl2 = l;
    tick;
    tv2 = 1'b0; tl2 = 1'b0;
  endtask

  task send1(input logic [7:0] d, input logic l);
    int w;
    w = 0;
    while (tr1 !== 1'b1 && w < 500) begin w++; tick; end
    tv1 = 1'b1; td1 = d; tl1 = l;
    tick;
    tv1 = 1'b0; tl1 = 1'b0;
  endtask

  task wait_cs_high2;
    int w;
    w = 0;
    while (cs2 === 1'b0 && w < 1000) begin w++; tick; end
  endtask

  task wait_cs_high1;
    int w;
    w = 0;
    while (cs1 === 1'b0 && w < 1000) begin w++; tick; end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, pos, ok, rvp, rwp, fp;
    rst2_n = 1'b0; rst1_n = 1'b0;
    tv2 = 1'b0; td2 = '0; tl2 = 1'b0;
    tv1 = 1'b0; td1 = '0; tl1 = 1'b0;
    for (int i = 0; i < 4; i++) begin resp2[i] = '0; resp1[i] = '0; end
    repeat (3) tick;

    // Reset values
    chk("rst_cs_n",     32'(cs2),   32'd1);
    chk("rst_sclk",     32'(sclk2), 32'd0);
    chk("rst_mosi",     32'(mosi2), 32'd0);
    chk("rst_tx_ready", 32'(tr2),   32'd0);
    chk("rst_rx_valid", 32'(rv2),   32'd0);
    chk("rst_rx_wvld",  32'(rwv2),  32'd0);
    chk("rst_rx_data",  32'(rd2),   32'd0);
    chk("rst_rx_word",  32'(rw2),   32'd0);
    chk("rst_busy",     32'(busy2), 32'd0);
    chk("rst1_cs_n",    32'(cs1),   32'd1);
    rst2_n = 1'b1; rst1_n = 1'b1;
    tick;
    chk("rdy_after_rst",  32'(tr2), 32'd1);
    chk("rdy1_after_rst", 32'(tr1), 32'd1);

    // Single byte 0xA5, slave returns 0x3C
    resp2[0] = 8'h3C; rvp = rv2_n; rwp = rwv2_n;
    tv2 = 1'b1; td2 = 8'hA5; tl2 = 1'b1;
    tick;
    tv2 = 1'b0; tl2 = 1'b0;
    chk("t1_cs_fall",   32'(cs2),   32'd0);
    chk("t1_busy",      32'(busy2), 32'd1);
    chk("t1_mosi_msb",  32'(mosi2), 32'd1);
    chk("t1_tx_ready",  32'(tr2),   32'd0);
    n = 0; pos = 0;
    while (cs2 === 1'b0 && n < 200) begin
      n++;
      if (rv2 === 1'b1 && pos == 0) pos = n;
      tick;
    end
    chk("t1_cs_low_cycles", 32'(n),   32'd34);
    chk("t1_rx_pulse_pos",  32'(pos), 32'd33);
    m = 0;
    while (tr2 !== 1'b1 && m < 100) begin m++; tick; end
    chk("t1_cs_high_before_rdy", 32'(m), 32'd2);
    chk("t1_busy_idle",  32'(busy2),         32'd0);
    chk("t1_rises",      32'(s2_rises),      32'd8);
    chk("t1_mosi_byte",  32'(s2_mb[0]),      32'hA5);
    chk("t1_rv_count",   32'(rv2_n - rvp),   32'd1);
    chk("t1_rx_data",    32'(rd2),           32'h3C);
    chk("t1_rwv_count",  32'(rwv2_n - rwp),  32'd0);

    // Two-byte frame 0x01, 0x80; slave returns 0x12, 0x34
    resp2[0] = 8'h12; resp2[1] = 8'h34;
    rvp = rv2_n; rwp = rwv2_n; fp = s2_falls;
    send2(8'h01, 1'b0);
    send2(8'h80, 1'b1);
    wait_cs_high2();
    chk("t2_cs_falls",  32'(s2_falls - fp), 32'd1);
    chk("t2_rises",     32'(s2_rises),      32'd16);
    chk("t2_mosi_b0",   32'(s2_mb[0]),      32'h01);
    chk("t2_mosi_b1",   32'(s2_mb[1]),      32'h80);
    chk("t2_rv_count",  32'(rv2_n - rvp),   32'd2);
    chk("t2_rwv_count", 32'(rwv2_n - rwp),  32'd1);
    chk("t2_rx_word",   32'(rw2),           32'h1234);
    chk("t2_rx_data",   32'(rd2),           32'h34);

    // Three-byte frame with a 50-cycle stall after the first byte
    resp2[0] = 8'h11; resp2[1] = 8'h22; resp2[2] = 8'h33;
    rvp = rv2_n; rwp = rwv2_n;
    send2(8'hAA, 1'b0);
    m = 0;
    while (tr2 !== 1'b1 && m < 200) begin m++; tick; end
    ok = 1;
    repeat (50) begin
      if (cs2 !== 1'b0 || sclk2 !== 1'b0 || tr2 !== 1'b1) ok = 0;
      tick;
    end
    chk("t3_stall_hold", 32'(ok),    32'd1);
    chk("t3_mosi_held", 32'(mosi2), 32'd0);
    tv2 = 1'b1; td2 = 8'hBB; tl2 = 1'b0;
    tick;
    tv2 = 1'b0;
    n = 0;
    while (sclk2 !== 1'b1 && n < 50) begin n++; tick; end
    chk("t3_first_rise_delay", 32'(n), 32'd2);
    send2(8'hCC, 1'b1);
    wait_cs_high2();
    chk("t3_rv_count",  32'(rv2_n - rvp),  32'd3);
    chk("t3_rwv_count", 32'(rwv2_n - rwp), 32'd1);
    chk("t3_rx_word",   32'(rw2),          32'h1122);
    chk("t3_rx_data",   32'(rd2),          32'h33);
    chk("t3_mosi_b2",   32'(s2_mb[2]),     32'hCC);
    chk("t3_rises",     32'(s2_rises),     32'd24);

    // Reset midway through bit 4, then a fresh frame
    m = 0;
    while (tr2 !== 1'b1 && m < 200) begin m++; tick; end
    resp2[0] = 8'hE7; rvp = rv2_n;
    send2(8'h96, 1'b1);
    repeat (14) tick;
    chk("t4_in_bit4_high", 32'(sclk2),    32'd1);
    chk("t4_rises_pre",    32'(s2_rises), 32'd4);
    #2 rst2_n = 1'b0;
    #1;
    chk("t4_async_cs_n", 32'(cs2),   32'd1);
    chk("t4_async_sclk", 32'(sclk2), 32'd0);
    chk("t4_async_busy", 32'(busy2), 32'd0);
    tick;
    tick;
    rst2_n = 1'b1;
    chk("t4_no_rx_pulse", 32'(rv2_n - rvp), 32'd0);
    chk("t4_rx_data_clr", 32'(rd2),         32'd0);
    resp2[0] = 8'hC3; rvp = rv2_n;
    send2(8'h5A, 1'b1);
    wait_cs_high2();
    chk("t4_mosi_byte", 32'(s2_mb[0]),    32'h5A);
    chk("t4_rx_data",   32'(rd2),         32'hC3);
    chk("t4_rv_count",  32'(rv2_n - rvp), 32'd1);
    chk("t4_rises",     32'(s2_rises),    32'd8);

    // CLK_DIV=1: back-to-back single-byte frames 0xFF then 0x00
    resp1[0] = 8'h81; rvp = rv1_n; rwp = rwv1_n;
    send1(8'hFF, 1'b1);
    chk("t5_sclk_c1", 32'(sclk1), 32'd0);
    tick;
    chk("t5_sclk_c2", 32'(sclk1), 32'd1);
    tick;
    chk("t5_sclk_c3", 32'(sclk1), 32'd0);
    tick;
    chk("t5_sclk_c4", 32'(sclk1), 32'd1);
    n = 3;
    while (cs1 === 1'b0 && n < 100) begin n++; tick; end
    chk("t5_cs_low_cycles", 32'(n),        32'd17);
    chk("t5_rx_data_0",     32'(rd1),      32'h81);
    chk("t5_mosi_b0",       32'(s1_mb[0]), 32'hFF);
    resp1[0] = 8'h7E;
    m = 0;
    while (cs1 === 1'b1 && m < 50) begin
      m++;
      if (tr1 === 1'b1) begin tv1 = 1'b1; td1 = 8'h00; tl1 = 1'b1; end
      else tv1 = 1'b0;
      tick;
    end
    tv1 = 1'b0; tl1 = 1'b0;
    chk("t5_cs_high_cycles", 32'(m), 32'd2);
    wait_cs_high1();
    chk("t5_rx_data_1",  32'(rd1),          32'h7E);
    chk("t5_mosi_b1",    32'(s1_mb[0]),     32'h00);
    chk("t5_rises",      32'(s1_rises),     32'd8);
    chk("t5_rv_count",   32'(rv1_n - rvp),  32'd2);
    chk("t5_rwv_count",  32'(rwv1_n - rwp), 32'd0);
    chk("t5_rx_word",    32'(rw1),          32'd0);
    chk("t5_busy",       32'(busy1),        32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
